trace_capture: RTL and testbench
================================

# trace_capture

Debug trace buffer sitting directly downstream of the single-cycle MIPS core. Each cycle, while capture is enabled, it snapshots the core's four debug buses (`pc_debug`, `instruction_debug`, `alu_result_debug`, `mem_data_debug`) as one 128-bit record and pushes it into a record FIFO. A serializer drains the FIFO as a valid/ready byte stream for a UART or host link. Records that arrive while the FIFO is full are dropped and counted.

## Interface
- `DEPTH`, default 8: FIFO depth in records. Must be a power of two and at least 2.
- `clk`, input, 1: the only clock.
- `reset`, input, 1: synchronous and active-high. Clears all state.
- `capture_en`, input, 1: when high on a rising edge, the current debug values are offered as a record.
- `pc_debug`, input, 32: core PC.
- `instruction_debug`, input, 32: core instruction.
- `alu_result_debug`, input, 32: core ALU result.
- `mem_data_debug`, input, 32: core data-memory read data.
- `clear_stats`, input, 1: clears `overflow` and `drop_count`.
- `out_valid`, output, 1: `out_data` holds a valid byte.
- `out_data`, output, 8: stream byte.
- `out_ready`, input, 1: the consumer accepts the byte on this edge.
- `fifo_level`, output, $clog2(DEPTH)+1: number of records held, including a partially sent head record.
- `overflow`, output, 1: sticky flag, set when any record has been dropped.
- `drop_count`, output, 16: number of dropped records. Saturates at 16'hFFFF.

## Operation
- **Push.** A push is attempted on an edge where `capture_en=1`.
  - Accepted if `fifo_level < DEPTH`, using the value before the edge.
  - When the FIFO is full, the record is dropped even if the head record completes on the same edge. No push-through.
  - A drop sets `overflow`. `drop_count` increments unless it is already 16'hFFFF.
- **Record layout.** 16 bytes, sent in this order:
  - `pc`, then `instr`, then `alu`, then `mem`.
  - Each word is sent big-endian, MSB byte first.
  - Byte k of the record is word k/4, bits [31-8*(k%4) -: 8].
- **Serializer.**
  - A 4-bit byte index starts at 0.
  - `out_valid = (fifo_level != 0)`.
  - `out_data` = byte[index] of the head record.
  - Handshake is `out_valid & out_ready`. On a handshake with index < 15, index increments.
  - On a handshake with index = 15, the head record is popped and index returns to 0.
- **Simultaneous push and pop.**
  - Not full: both happen and `fifo_level` is unchanged.
  - Full: pop only, and the push is dropped as above.
- **Pointer wrap.**
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - The level is tracked separately, so the full and empty states are unambiguous.
- **clear_stats.**
  - `clear_stats=1` zeroes `overflow` and `drop_count`.
  - If a drop occurs on the same edge, the result is `drop_count=1` and `overflow=1`.
  - `clear_stats` does not affect FIFO contents.
- **Reset.**
  - `fifo_level=0`, pointers=0, index=0, `overflow=0`, `drop_count=0`, `out_valid=0`, `out_data=0`.
  - A record that is partially sent when reset asserts is discarded. Bytes already sent are not resent.
  - `capture_en` is ignored on the reset edge.

## Timing
- A record captured on edge N is presented as byte 0 with `out_valid=1` after edge N, provided the FIFO was empty. Latency is 1 cycle.
- `out_data` and `out_valid` stay stable while `out_valid=1` and `out_ready=0`.
- `out_data` changes only after a handshake edge, a push into an empty FIFO, or reset.
- With `out_ready` held high, throughput is 1 byte/cycle, so one record is sent per 16 cycles. Back-to-back records are sent with no gap byte.
- `fifo_level`, `overflow` and `drop_count` are registered and update on the edge that causes the change.
- With `out_valid=0`, `out_data` reads 0.

## Test plan
1. **Single record.** After reset, pulse `capture_en` once with pc=0x00400000, instr=0x8C080004, alu=0x10010004, mem=0xDEADBEEF, and hold `out_ready=1`.
   - Expect `out_valid` high the next cycle.
   - Expect the bytes 00 40 00 00 8C 08 00 04 10 01 00 04 DE AD BE EF on 16 consecutive cycles, then `out_valid=0`.
   - Expect `fifo_level` to go 1, then 0.
2. **Backpressure.** As in test 1, but toggle `out_ready` pseudo-randomly.
   - Expect `out_data` to be held whenever `out_ready=0`.
   - Expect the same 16-byte sequence with no byte repeated or skipped.
3. **Overflow.** DEPTH=8, `out_ready=0`, hold `capture_en` for 11 cycles with pc=0..10.
   - Expect `fifo_level=8`, `overflow=1`, `drop_count=3`.
   - Then drain: expect records with pc=0..7 only.
4. **Full with simultaneous pop.** Fill the FIFO, send 15 bytes of the head, then on one edge assert both `out_ready` and `capture_en`.
   - Expect the head popped, `fifo_level=7`, `drop_count` incremented by 1.
5. **clear_stats.**
   - `clear_stats` alone with `drop_count=5`: expect `drop_count=0` and `overflow=0`.
   - `clear_stats` on the same edge as a drop: expect `drop_count=1` and `overflow=1`.
6. **Reset mid-record.** Assert `reset` after 6 bytes of a record.
   - Expect `out_valid=0`, `fifo_level=0`, `out_data=0` the next cycle.
   - Expect a new capture to start at byte 0.

Source files
------------

// File: rtl/trace_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture_if
// Purpose  : Debug-bus capture inputs and byte-stream handshake for
//            trace_capture.
// Revision : 1.0  initial release
// ============================================================================
interface trace_capture_if;
    logic        capture_en;
    logic [31:0] pc_debug;
    logic [31:0] instruction_debug;
    logic [31:0] alu_result_debug;
    logic [31:0] mem_data_debug;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    // Host / core side: drives the debug buses and consumes the stream.
    modport master (
        output capture_en, pc_debug, instruction_debug, alu_result_debug,
               mem_data_debug, out_ready,
        input  out_valid, out_data
    );

    // Trace buffer side.
    modport slave (
        input  capture_en, pc_debug, instruction_debug, alu_result_debug,
               mem_data_debug, out_ready,
        output out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture
// Purpose  : Captures 128-bit MIPS debug records into a FIFO and serialises
//            them MSB-byte-first as a valid/ready byte stream.
// Revision : 1.0  initial release
// ============================================================================
module trace_capture #(
    parameter int DEPTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    trace_capture_if.slave              tc,
    input  wire logic                   clear_stats,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic                        overflow,
    output logic [15:0]                 drop_count
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [127:0]       r_mem [DEPTH];
    logic [c_AW-1:0]    r_wptr;
    logic [c_AW-1:0]    r_rptr;
    logic [c_AW:0]      r_level;
    logic [3:0]         r_idx;
    logic               r_overflow;
    logic [15:0]        r_drop_count;

    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_valid;
    logic               w_hs;
    logic               w_pop;
    logic [127:0]       w_head;
    logic [7:0]         w_byte;

    // Fullness uses the pre-edge level, so a same-edge pop never frees a slot.
    assign w_full  = (r_level == c_FULL);
    assign w_push  = tc.capture_en & ~w_full & ~reset;
    assign w_drop  = tc.capture_en &  w_full & ~reset;
    assign w_valid = (r_level != '0);
    assign w_hs    = w_valid & tc.out_ready;
    assign w_pop   = w_hs & (r_idx == 4'd15);

    // Byte k sits at bits [127-8k -: 8]; 15-k equals ~k for a 4-bit index.
    assign w_head  = r_mem[r_rptr];
    assign w_byte  = 8'(w_head >> {~r_idx, 3'b000});

    assign tc.out_valid = w_valid;
    assign tc.out_data  = w_valid ? w_byte : 8'h00;
    assign fifo_level   = r_level;
    assign overflow     = r_overflow;
    assign drop_count   = r_drop_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {tc.pc_debug, tc.instruction_debug,
                              tc.alu_result_debug, tc.mem_data_debug};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_idx   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_hs) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_AW+1)'(1);
                2'b01:   r_level <= r_level - (c_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop coinciding with clear_stats leaves exactly that one drop counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear_stats) begin
            r_overflow   <= w_drop;
            r_drop_count <= {15'd0, w_drop};
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_capture
// Purpose  : Scoreboard bench for trace_capture: expected stream bytes are
//            queued at capture time and popped by an independent monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_trace_capture;

    localparam int c_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_stats;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    trace_capture_if bus ();

    trace_capture #(.DEPTH(c_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .tc          (bus),
        .clear_stats (clear_stats),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: the outstanding byte stream plus statistics.
    logic [7:0]  q[$];
    logic [15:0] m_drop = '0;
    logic        m_ovf  = 1'b0;
    bit          mon_en = 1'b0;
    int          total  = 0;
    int          bad    = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_level();
        return (q.size() + 15) / 16;
    endfunction

    // One clock edge: drive inputs, predict its effect, apply it to the model.
    task automatic step(bit cap, logic [31:0] pc, logic [31:0] ins,
                        logic [31:0] alu, logic [31:0] mem,
                        bit rdy, bit clr, bit rst);
        logic [31:0] w [4];
        bit acc, drp;
        bus.capture_en        = cap;
        bus.pc_debug          = pc;
        bus.instruction_debug = ins;
        bus.alu_result_debug  = alu;
        bus.mem_data_debug    = mem;
        bus.out_ready         = rdy;
        clear_stats           = clr;
        reset                 = rst;
        acc = !rst && cap && (m_level() <  c_DEPTH);
        drp = !rst && cap && (m_level() >= c_DEPTH);
        w = '{pc, ins, alu, mem};
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_drop = '0;
            m_ovf  = 1'b0;
        end else begin
            if (acc) begin
                for (int k = 0; k < 16; k++)
                    q.push_back(8'(w[k/4] >> (24 - 8*(k%4))));
            end
            if (clr) begin
                m_ovf  = drp;
                m_drop = drp ? 16'd1 : 16'd0;
            end else if (drp) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, rdy, 0, 0);
    endtask

    // Monitor: compares at the falling edge, consumes on the following rise.
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (mon_en) begin
                check("out_valid",  32'(bus.out_valid), 32'(q.size() != 0));
                check("out_data",   32'(bus.out_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
                check("fifo_level", 32'(fifo_level),    32'(m_level()));
                check("overflow",   32'(overflow),      32'(m_ovf));
                check("drop_count", 32'(drop_count),    32'(m_drop));
                hs = (q.size() != 0) && bus.out_ready;
            end
            @(posedge clk);
            if (hs && q.size() != 0) void'(q.pop_front());
        end
    end

    initial begin
        int d0;
        step(0, '0, '0, '0, '0, 0, 0, 1);
        step(1, 32'h1, 32'h2, 32'h3, 32'h4, 1, 0, 1);
        mon_en = 1'b1;
        idle(2, 1);

        // Single record, consumer always ready.
        step(1, 32'h00400000, 32'h8C080004, 32'h10010004, 32'hDEADBEEF, 1, 0, 0);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_byte0", 32'(bus.out_data), 32'h00);
        check("t1_level", 32'(fifo_level), 32'd1);
        idle(16, 1);
        check("t1_empty", 32'(bus.out_valid), 32'd0);

        // Same record under random backpressure.
        step(1, 32'h00400000, 32'h8C080004, 32'h10010004, 32'hDEADBEEF,
             bit'($urandom_range(0, 1)), 0, 0);
        for (int i = 0; i < 80; i++) step(0, '0, '0, '0, '0, bit'($urandom_range(0, 1)), 0, 0);
        idle(20, 1);

        // Overflow: 11 captures into a stalled 8-deep FIFO.
        for (int i = 0; i <= 10; i++) step(1, 32'(i), 32'h11, 32'h22, 32'h33, 0, 0, 0);
        check("t3_level", 32'(fifo_level), 32'd8);
        check("t3_ovf",   32'(overflow),   32'd1);
        check("t3_drop",  32'(drop_count), 32'd3);
        idle(8*16 + 4, 1);

        // Full FIFO, head completes on the same edge as a capture.
        for (int i = 0; i < 8; i++) step(1, 32'(100 + i), $urandom, $urandom, $urandom, 0, 0, 0);
        idle(15, 1);
        d0 = int'(drop_count);
        step(1, 32'hBAD, 32'hBAD, 32'hBAD, 32'hBAD, 1, 0, 0);
        check("t4_level", 32'(fifo_level), 32'd7);
        check("t4_drop",  32'(drop_count), 32'(d0 + 1));

        // clear_stats alone and coinciding with a drop.
        step(1, 32'h200, $urandom, $urandom, $urandom, 0, 0, 0);
        step(0, '0, '0, '0, '0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h300, '0, '0, '0, 0, 0, 0);
        check("t5_drop5", 32'(drop_count), 32'd5);
        step(0, '0, '0, '0, '0, 0, 1, 0);
        check("t5_clr_drop", 32'(drop_count), 32'd0);
        check("t5_clr_ovf",  32'(overflow),   32'd0);
        step(1, 32'h301, '0, '0, '0, 0, 1, 0);
        check("t5_both_drop", 32'(drop_count), 32'd1);
        check("t5_both_ovf",  32'(overflow),   32'd1);

        // Reset part-way through a record.
        step(0, '0, '0, '0, '0, 0, 0, 1);
        step(1, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'h55AA55AA, 1, 0, 0);
        idle(6, 1);
        step(0, '0, '0, '0, '0, 0, 0, 1);
        check("t6_valid", 32'(bus.out_valid), 32'd0);
        check("t6_level", 32'(fifo_level),    32'd0);
        check("t6_data",  32'(bus.out_data),  32'd0);
        step(1, 32'hA1B2C3D4, 32'hE5F60718, 32'h293A4B5C, 32'h6D7E8F90, 1, 0, 0);
        check("t6_byte0", 32'(bus.out_data), 32'hA1);
        idle(20, 1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++)
            step(bit'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                 bit'($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 199) == 0));
        idle(c_DEPTH*16 + 8, 1);
        check("final_level", 32'(fifo_level),    32'd0);
        check("final_valid", 32'(bus.out_valid), 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
